// File: rtl/rec_data_cnt_pkg.sv
// Shared definitions for the CAN receive data-field counter: state encoding,
// default frame length limit and the length clamp helper.
package rec_data_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int MAXLEN_DEFAULT = 8;

    // DLC values above the frame limit (e.g. 9..15) still mean "maxlen bytes".
    function automatic logic [3:0] clamp_len(input logic [3:0] rmlb, input int maxlen);
        return (int'(rmlb) > maxlen) ? 4'(maxlen) : rmlb;
    endfunction

endpackage

// File: rtl/rec_data_buf.sv
// Received-byte store: DEPTH x 8 entries written by the byte strobe,
// read combinationally by index. Only built with REC_DATA_CNT_BUF_EN.
module rec_data_buf #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_idx,
    output logic [7:0] rd_data
);

    logic [DEPTH-1:0][7:0] mem_q;

    // One register per entry so the whole store can be cleared by reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (reset) begin
                mem_q[gi] <= 8'h00;
            end else if (wr_en && (wr_idx == 3'(gi))) begin
                mem_q[gi] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/rec_data_cnt.sv
// CAN receive data-field assembler: packs destuffed bits MSB-first into bytes
// and strobes each byte out. Optional byte store enabled by REC_DATA_CNT_BUF_EN.
module rec_data_cnt
    import rec_data_cnt_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rmlb,
    input  logic       bitval,
    input  logic       bitin,
    input  logic       abort,
    output logic [7:0] byte_data,
    output logic       byte_wr,
    output logic [2:0] byte_idx,
    output logic       busy,
    output logic       done
`ifdef REC_DATA_CNT_BUF_EN
    ,
    input  logic [2:0] rdidx,
    output logic [7:0] rddata
`endif
);

    state_e     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic [2:0] byte_idx_q, byte_idx_d;
    logic       byte_wr_q, byte_wr_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        byte_data_d = byte_data_q;
        byte_idx_d  = byte_idx_q;
        byte_wr_d   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else if (start) begin
            len_d      = clamp_len(rmlb, MAXLEN);
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            shift_d    = 8'h00;
            state_d    = (len_d != 4'd0) ? ST_SHIFT : ST_DONE;
        end else begin
            unique case (state_q)
                ST_SHIFT: begin
                    if (bitval) begin
                        shift_d   = {shift_q[6:0], bitin};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // Eighth bit completes the byte; it goes straight to the output register.
                        if (bit_cnt_q == 3'd7) begin
                            byte_data_d = {shift_q[6:0], bitin};
                            byte_idx_d  = byte_cnt_q;
                            byte_wr_d   = 1'b1;
                            byte_cnt_d  = byte_cnt_q + 3'd1;
                            if ({1'b0, byte_cnt_q} == (len_q - 4'd1)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= 4'd0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            shift_q     <= 8'h00;
            byte_data_q <= 8'h00;
            byte_idx_q  <= 3'd0;
            byte_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            byte_data_q <= byte_data_d;
            byte_idx_q  <= byte_idx_d;
            byte_wr_q   <= byte_wr_d;
        end
    end

    // DONE lasts one cycle and is entered on the final byte edge, so done
    // lines up with the last byte_wr.
    assign byte_data = byte_data_q;
    assign byte_idx  = byte_idx_q;
    assign byte_wr   = byte_wr_q;
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

`ifdef REC_DATA_CNT_BUF_EN
    rec_data_buf #(
        .DEPTH (MAXLEN)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (byte_wr_q),
        .wr_idx  (byte_idx_q),
        .wr_data (byte_data_q),
        .rd_idx  (rdidx),
        .rd_data (rddata)
    );
`endif

endmodule

// File: doc/rec_data_cnt.md
REC_DATA_CNT -- requirements
Module: rec_data_cnt

Interface
REQ-001 SHALL have parameter MAXLEN, default 8, maximum data bytes per frame; any rmlb above MAXLEN is clamped to it.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse from macfsm at the start of the data field.
REQ-005 SHALL have port rmlb  input  4  received data length in bytes from the length register (0 for RTR).
REQ-006 SHALL have port bitval  input  1  one-cycle strobe per valid destuffed data bit.
REQ-007 SHALL have port bitin  input  1  data bit value, qualified by bitval.
REQ-008 SHALL have port abort  input  1  error or arbitration loss; cancels reception.
REQ-009 SHALL have port byte_data  output  8  assembled byte, MSB received first.
REQ-010 SHALL have port byte_wr  output  1  one-cycle write strobe for byte_data.
REQ-011 SHALL have port byte_idx  output  3  byte position 0..7 of byte_data.
REQ-012 SHALL have port busy  output  1  high while in state SHIFT.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the data field is complete.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 SHALL, on start in any state, latch len = min(rmlb, MAXLEN), clear the bit and byte counters, and go to SHIFT (len>0) or DONE (len=0).
REQ-016 SHALL, in SHIFT, on bitval, shift bitin into an 8-bit register LSB-side, so the first received bit ends as bit 7, and increment a 3-bit bit counter.
REQ-017 SHALL, on the edge that samples the 8th bitval of a byte, register byte_data, set byte_idx to the current byte count, assert byte_wr for exactly the following cycle, and increment the byte count.
REQ-018 SHALL, when that byte is byte len-1, go to DONE so that done is asserted in the same cycle as the final byte_wr.
REQ-019 SHALL, for len=0, assert done in the cycle after start with no byte_wr.
REQ-020 SHALL go from DONE to IDLE after one cycle; done and byte_wr are never high for more than one cycle.
REQ-021 SHALL ignore bitval in IDLE and DONE.
REQ-022 SHALL, on abort in SHIFT, go to IDLE with no byte_wr and no done, discarding any partial byte.
REQ-023 SHALL give priority, on simultaneous events, as reset > abort > start > bitval.
REQ-024 SHALL not change len when rmlb changes during SHIFT.

Reset
REQ-025 SHALL, on reset, go to IDLE and clear byte_data, byte_idx, byte_wr, busy, done, len and both counters to 0.
REQ-026 SHALL, on reset mid-SHIFT, produce no further byte_wr or done.

Configuration
REQ-027 SHALL, when REC_DATA_CNT_BUF_EN is defined, add an internal MAXLEN x 8 buffer written on byte_wr, plus ports rdidx (input, 3 bits) and rddata (output, 8 bits, combinational read); the buffer is cleared on reset.
REQ-028 SHALL, without REC_DATA_CNT_BUF_EN, omit the buffer and both ports, leaving all other behaviour identical.

Structure
REQ-029 SHALL place the state encoding and the MAXLEN default in the shared CAN package.
REQ-030 SHALL put the optional buffer in sub-module rec_data_buf; the control logic stays flat.

Verification
REQ-031 SHALL verify: rmlb=2, start, 16 bits A5h then 3Ch -> byte_wr at idx0=A5h and idx1=3Ch, with done coincident with the second byte_wr.
REQ-032 SHALL verify: rmlb=0, start -> done one cycle later, no byte_wr, busy never high.
REQ-033 SHALL verify: rmlb=15, start, 64 bits -> exactly 8 byte_wr at idx 0..7, then done; later bitvals ignored.
REQ-034 SHALL verify: rmlb=3, abort after 12 bits -> one byte_wr only, no done, state IDLE; a following start with rmlb=1 and 8 bits FFh -> byte_wr FFh at idx0 plus done.
REQ-035 SHALL verify: reset asserted with bitval and start during SHIFT -> all outputs 0 next cycle and no done.
REQ-036 SHALL verify, with REC_DATA_CNT_BUF_EN: after REQ-031, rdidx=1 gives rddata=3Ch.
